alu_mul_sequencer: RTL and testbench

//  Multi-cycle 16-bit multiplier controller built around the shared Hack ALU (x,y,zx,nx,zy,ny,f,no).

---
 rtl/alu_mul_sequencer.sv | 135 +++++++++++++
 tb/tb_alu_mul_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle shift-and-add multiplier that borrows the shared Hack ALU for all additions.
// Each iteration takes one ALU add for the partial product and one doubling pass for the multiplicand.
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter int ITERS = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             res_zr,
  output logic             res_ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [5:0]       alu_ctl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  localparam int CW = $clog2(ITERS) + 1;

  // {zx,nx,zy,ny,f,no}
  localparam logic [5:0] ALU_ZERO  = 6'b101010;
  localparam logic [5:0] ALU_PASSX = 6'b001100;
  localparam logic [5:0] ALU_ADD   = 6'b000010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_DBL,
    S_FLAG,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [CW-1:0]    count;
  logic             last_iter;

  assign last_iter = (count == CW'(ITERS - 1));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    alu_x      = '0;
    alu_y      = '0;
    alu_ctl    = ALU_ZERO;
    case (state)
      S_IDLE: begin
        if (start) next_state = S_ADD;
      end
      S_ADD: begin
        // A zero multiplier bit still routes prod through the ALU so the ADD step always writes prod.
        alu_x = prod;
        if (mplr[0]) begin
          alu_y   = mcand;
          alu_ctl = ALU_ADD;
        end else begin
          alu_ctl = ALU_PASSX;
        end
        next_state = S_DBL;
      end
      S_DBL: begin
        alu_x      = mcand;
        alu_y      = mcand;
        alu_ctl    = ALU_ADD;
        next_state = last_iter ? S_FLAG : S_ADD;
      end
      S_FLAG: begin
        alu_x      = prod;
        alu_ctl    = ALU_PASSX;
        next_state = S_DONE;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prod   <= '0;
      mcand  <= '0;
      mplr   <= '0;
      count  <= '0;
      result <= '0;
      res_zr <= 1'b0;
      res_ng <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            prod  <= '0;
            mcand <= a;
            mplr  <= b;
            count <= '0;
          end
        end
        S_ADD: begin
          prod <= alu_out;
        end
        S_DBL: begin
          mcand <= alu_out;
          mplr  <= mplr >> 1;
          count <= count + 1'b1;
        end
        S_FLAG: begin
          result <= alu_out;
          res_zr <= alu_zr;
          res_ng <= alu_ng;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: a Hack ALU closes the loop, and an arithmetic
// model of each operation's phase sequence is compared against the DUT on every cycle.
module tb_alu_mul_sequencer;

  localparam logic [5:0] ALU_ZERO  = 6'b101010;
  localparam logic [5:0] ALU_PASSX = 6'b001100;
  localparam logic [5:0] ALU_ADD   = 6'b000010;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        res_zr;
  logic        res_ng;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  int total  = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  alu_mul_sequencer #(.WIDTH(16), .ITERS(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .res_zr  (res_zr),
    .res_ng  (res_ng),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_ctl (alu_ctl),
    .alu_out (alu_out),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng)
  );

  always #5 clock = ~clock;

  // Hack ALU, ctl = {zx,nx,zy,ny,f,no}
  logic [15:0] hx, hy, ho;
  always_comb begin
    hx = alu_x;
    hy = alu_y;
    if (alu_ctl[5]) hx = '0;
    if (alu_ctl[4]) hx = ~hx;
    if (alu_ctl[3]) hy = '0;
    if (alu_ctl[2]) hy = ~hy;
    ho = alu_ctl[1] ? hx + hy : hx & hy;
    if (alu_ctl[0]) ho = ~ho;
    alu_out = ho;
    alu_zr  = (ho == 16'h0000);
    alu_ng  = ho[15];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  // Model: ph is the cycle number within an operation (1..34), 0 when idle.
  int unsigned ph    = 0;
  int unsigned op_a  = 0;
  int unsigned op_b  = 0;
  int unsigned m_res = 0;
  bit          m_zr  = 1'b0;
  bit          m_ng  = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      ph    <= 0;
      m_res <= 0;
      m_zr  <= 1'b0;
      m_ng  <= 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        ph   <= 1;
        op_a <= 32'(a);
        op_b <= 32'(b);
      end
    end else if (ph == 33) begin
      m_res <= (op_a * op_b) & 32'hFFFF;
      m_zr  <= (((op_a * op_b) & 32'hFFFF) == 0);
      m_ng  <= (((op_a * op_b) >> 15) & 32'd1) == 1;
      ph    <= 34;
    end else if (ph == 34) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge clock) begin
    int unsigned i, sh, pp;
    bit          mb;
    if (chk_en) begin
      check("busy", 32'(busy), 32'(ph != 0));
      check("done", 32'(done), 32'(ph == 34));
      check("result", 32'(result), m_res);
      check("res_zr", 32'(res_zr), 32'(m_zr));
      check("res_ng", 32'(res_ng), 32'(m_ng));
      if (ph == 0) begin
        check("idle_ctl", 32'(alu_ctl), 32'(ALU_ZERO));
        check("idle_x", 32'(alu_x), 0);
        check("idle_y", 32'(alu_y), 0);
      end else if (ph <= 32) begin
        i  = (ph - 1) / 2;
        sh = (op_a << i) & 32'hFFFF;
        if (ph % 2 == 1) begin
          pp = (op_a * (op_b & ((32'd1 << i) - 1))) & 32'hFFFF;
          mb = op_b[i];
          check("add_ctl", 32'(alu_ctl), mb ? 32'(ALU_ADD) : 32'(ALU_PASSX));
          check("add_x", 32'(alu_x), pp);
          check("add_y", 32'(alu_y), mb ? sh : 0);
        end else begin
          check("dbl_ctl", 32'(alu_ctl), 32'(ALU_ADD));
          check("dbl_x", 32'(alu_x), sh);
          check("dbl_y", 32'(alu_y), sh);
        end
      end else if (ph == 33) begin
        check("flag_ctl", 32'(alu_ctl), 32'(ALU_PASSX));
        check("flag_x", 32'(alu_x), (op_a * op_b) & 32'hFFFF);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts an op from an IDLE cycle, optionally pokes start in cycles s1/s2, returns in IDLE.
  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob,
                        input int s1, input int s2, input bit poke_done, output int lat);
    a = oa; b = ob; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (lat == s1 || lat == s2) begin
        start = 1'b1;
        a = 16'($urandom);
        b = 16'($urandom);
      end
      tick();
      start = 1'b0;
      lat++;
    end
    if (!done) lat = 0;
    check("latency", 32'(lat), 34);
    if (poke_done) begin
      start = 1'b1;
      a = 16'($urandom);
      b = 16'($urandom);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic pinned(input logic [15:0] oa, input logic [15:0] ob, input int s1, input int s2,
                        input logic [15:0] er, input bit ez, input bit en);
    int lat;
    run_op(oa, ob, s1, s2, 1'b0, lat);
    check("pin_result", 32'(result), 32'(er));
    check("pin_zr", 32'(res_zr), 32'(ez));
    check("pin_ng", 32'(res_ng), 32'(en));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 4))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int lat, seen;
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, seen;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_zr", 32'(res_zr), 0);
    check("rst_ng", 32'(res_ng), 0);
    check("rst_ctl", 32'(alu_ctl), 32'(ALU_ZERO));
    chk_en = 1'b1;

    pinned(16'd3,    16'd5,    0, 0, 16'd15,   1'b0, 1'b0);
    pinned(16'h1234, 16'h0000, 0, 0, 16'h0000, 1'b1, 1'b0);
    pinned(16'hFFFF, 16'hFFFF, 0, 0, 16'h0001, 1'b0, 1'b0);
    pinned(16'h0100, 16'h0100, 0, 0, 16'h0000, 1'b1, 1'b0);
    pinned(16'h4000, 16'h0002, 0, 0, 16'h8000, 1'b0, 1'b1);
    pinned(16'hFFFD, 16'h0007, 0, 0, 16'hFFEB, 1'b0, 1'b1);
    pinned(16'd7,    16'd9,    5, 20, 16'd63,  1'b0, 1'b0);

    // Abort an op with reset in its tenth cycle.
    a = 16'h0123; b = 16'h0045; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_result", 32'(result), 0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) seen++;
      tick();
    end
    check("abort_no_done", 32'(seen), 0);

    // Reset and start together: reset wins.
    reset = 1'b1; start = 1'b1; a = 16'd2; b = 16'd2;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rststart_busy", 32'(busy), 0);
    tick();
    check("rststart_busy2", 32'(busy), 0);

    for (int k = 0; k < 24; k++) begin
      run_op(pick(), pick(), int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
             1'($urandom_range(0, 1)), lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
